adder4_rr_arbiter: RTL and testbench
====================================

Name: adder4_rr_arbiter

Overview:
- Shares one 4-bit Kogge-Stone adder datapath between NUM_REQ requesters.
- Each requester presents an operand pair through a valid/ready handshake. A round-robin arbiter picks one requester per cycle and drives its operands into the shared adder.
- The sum, carry-out and requester ID are captured in a single-entry output register, which is drained through its own valid/ready handshake.
- Sits between the per-lane operand sources and the result consumer. The adder is instantiated internally and is purely combinational.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester ID; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  bit i: requester i presents an operand pair.
- req_a  input  4*NUM_REQ  operand A; requester i uses bits [4i+3:4i].
- req_b  input  4*NUM_REQ  operand B; requester i uses bits [4i+3:4i].
- req_ready  output  NUM_REQ  one-hot or zero; bit i high means requester i's pair is accepted this cycle.
- res_valid  output  1  output register holds a result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_sum  output  4  (a+b) mod 16 of the accepted pair.
- res_cout  output  1  bit 4 of a+b.
- res_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset: clk is the single clock. rst_n is asynchronous, active-low, with synchronous deassertion assumed at the system level. While rst_n=0:
  - res_valid=0, res_sum=0, res_cout=0, res_id=0.
  - rr pointer=0.
  - req_ready=0.
- Reset mid-operation: any held result is discarded. No handshake completes in the reset cycle.
- State machine, two states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain+accept in the same cycle, or on no drain.
- Drain: res_valid & res_ready.
- Accept enable: accept_en = (state==EMPTY) | (res_valid & res_ready). Full throughput of 1 result/cycle is sustained under constant res_ready=1.
- Arbitration:
  - Search requesters ptr, ptr+1, …, ptr+NUM_REQ-1 (mod NUM_REQ). Grant the first with req_valid=1.
  - req_ready[g] = accept_en & req_valid[g]; all other bits are 0.
  - req_ready is combinational from req_valid, res_ready and state.
- Accept (any req_ready bit high):
  - Output register loads sum, cout and id=g.
  - Pointer updates to (g+1) mod NUM_REQ.
  - With no accept, the pointer holds.
- Latency: result is visible on res_* the cycle after acceptance.
- Output stability: res_sum, res_cout and res_id stay stable while res_valid=1 and res_ready=0.
- Requester rule: once req_valid[i] rises, requester i holds it and its operands stable until req_ready[i]. The block does not check this.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Arithmetic: 4-bit unsigned, no carry-in. Wrap-around: 0xF+0x1 gives sum=0x0, cout=1.
- Idle: no req_valid leaves state and pointer unchanged.

Optional Feature:
- Macro: ADDER4_ARB_STATS_EN.
- Defined:
  - Adds output port txn_count, 16 bits.
  - txn_count increments by 1 on every accept and saturates at 0xFFFF. It never wraps.
  - Reset value is 0 (async via rst_n).
  - The increment takes effect the same edge the result register loads.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/single request: reset, then req_valid=0001, a0=3, b0=4, res_ready=1 -> req_ready=0001 same cycle; next cycle res_valid=1, sum=7, cout=0, id=0; pointer=1.
- Overflow: requester 2 sends a=0xF, b=0x1 -> sum=0x0, cout=1, id=2.
- Round-robin fairness: all four valid continuously, res_ready=1 from reset -> grant order 0,1,2,3,0,…; one result every cycle with ids in the same order.
- Backpressure: fill register (req0 a=5, b=5), then hold res_ready=0 for 3 cycles with req1 valid -> req_ready=0, res_sum=0xA and res_id=0 stable. Raise res_ready -> req1 is accepted in that same cycle and its result appears on the next cycle.
- Mid-operation reset: res_valid=1, drop rst_n asynchronously between edges -> res_valid=0 and all res_* outputs are 0 immediately. After release, the first grant goes to requester 0.
- Stats (ADDER4_ARB_STATS_EN defined): 5 accepts -> txn_count=5. Force 70000 accepts -> txn_count=0xFFFF and holds.

Source files
------------

// File: rtl/adder4_rr_arbiter.sv
// adder4_rr_arbiter: NUM_REQ requesters share one combinational 4-bit
// Kogge-Stone adder through a round-robin arbiter. Results land in a
// single-entry output register drained by a valid/ready handshake.
// Optional build macro: ADDER4_ARB_STATS_EN adds a saturating 16-bit
// accept counter on port txn_count.

// 4-bit Kogge-Stone adder, no carry-in. Two prefix levels (span 1, span 2).
module adder4_rr_arbiter_ks4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g0, p0;
  logic [3:0] g1, p1;
  logic [3:0] g2, p2;
  logic [3:0] carry;

  // Bitwise generate/propagate and the two prefix levels.
  always_comb begin
    g0 = a & b;
    p0 = a ^ b;

    g1[0] = g0[0];
    p1[0] = p0[0];
    for (int i = 1; i < 4; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end

    g2[1:0] = g1[1:0];
    p2[1:0] = p1[1:0];
    for (int i = 2; i < 4; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
  end

  // Carry into bit i is the group generate of bits [i-1:0].
  always_comb begin
    carry = {g2[2:0], 1'b0};
    sum   = p0 ^ carry;
    cout  = g2[3];
  end

endmodule

// State table
//   state | meaning
//   EMPTY | output register holds nothing, res_valid=0
//   FULL  | output register holds a result, res_valid=1
module adder4_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [3:0]             res_sum,
  output logic                   res_cout,
  output logic [ID_W-1:0]        res_id
`ifdef ADDER4_ARB_STATS_EN
  ,
  output logic [15:0]            txn_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [ID_W:0]   NREQ_EXT = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic [ID_W:0]   cand;
  logic            drain;
  logic            accept_en;
  logic            accept;
  logic [3:0]      sel_a, sel_b;
  logic [3:0]      add_sum;
  logic            add_cout;

  // Rotating priority search starting at rr_ptr; cand wraps modulo NUM_REQ
  // so non-power-of-two requester counts never index past the vector.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Handshake qualification. rst_n gates req_ready so nothing is accepted
  // while reset is held.
  always_comb begin
    res_valid = (state_q == FULL);
    drain     = res_valid & res_ready;
    accept_en = (state_q == EMPTY) | drain;
    accept    = accept_en & grant_found & rst_n;
    req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Operand mux into the shared adder.
  always_comb begin
    sel_a = req_a[{grant_idx, 2'b00} +: 4];
    sel_b = req_b[{grant_idx, 2'b00} +: 4];
  end

  adder4_rr_arbiter_ks4 u_adder (
    .a    (sel_a),
    .b    (sel_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a same-cycle drain+accept keeps the register FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Result register loads only on accept, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_id   <= '0;
    end else if (accept) begin
      res_sum  <= add_sum;
      res_cout <= add_cout;
      res_id   <= grant_idx;
    end
  end

  // Round-robin pointer moves just past the winner; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef ADDER4_ARB_STATS_EN
  // Saturating accept counter, updated on the same edge as the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (accept && (txn_count != 16'hFFFF)) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder4_rr_arbiter.sv
// tb_adder4_rr_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the arbiter and adder.
module tb_adder4_rr_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [4*N-1:0]   req_a;
  logic [4*N-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_sum;
  logic             res_cout;
  logic [ID_W-1:0]  res_id;
`ifdef ADDER4_ARB_STATS_EN
  logic [15:0]      txn_count;
`endif

  logic [3:0] a_arr [N];
  logic [3:0] b_arr [N];

  int n_checks;
  int n_fail;

  // model state
  bit m_full;
  int m_sum, m_cout, m_id, m_ptr, m_cnt;
  int last_grant;

  adder4_rr_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
`ifdef ADDER4_ARB_STATS_EN
    ,
    .txn_count (txn_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pack per-requester operands
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4] = a_arr[i];
      req_b[4*i +: 4] = b_arr[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_sum = 0; m_cout = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    last_grant = -1;
  endtask

  // One cycle: compare at negedge against the model, then advance the model
  // across the posedge. Inputs must already be driven.
  task automatic step();
    int g;
    int idx;
    int total;
    bit acc;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx] && g < 0) g = idx;
    end
    acc = (!m_full || res_ready) && (g >= 0);
    exp_ready = acc ? (N'(1) << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(m_full));
    if (m_full) begin
      check("res_sum", 32'(res_sum), 32'(m_sum));
      check("res_cout", 32'(res_cout), 32'(m_cout));
      check("res_id", 32'(res_id), 32'(m_id));
    end
`ifdef ADDER4_ARB_STATS_EN
    check("txn_count", 32'(txn_count), 32'(m_cnt));
`endif
    @(posedge clk);
    if (acc) begin
      total  = int'(a_arr[g]) + int'(b_arr[g]);
      m_full = 1;
      m_sum  = total % 16;
      m_cout = total / 16;
      m_id   = g;
      m_ptr  = (g + 1) % N;
      if (m_cnt < 65535) m_cnt++;
      last_grant = g;
    end else begin
      if (m_full && res_ready) m_full = 0;
      last_grant = -1;
    end
    #1;
  endtask

  // Assert reset between edges, verify reset outputs, release near negedge.
  task automatic apply_reset();
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_cout", 32'(res_cout), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input int i);
    a_arr[i] = 4'($urandom_range(0, 15));
    b_arr[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    apply_reset();

    // single request
    req_valid = 4'b0001; a_arr[0] = 4'd3; b_arr[0] = 4'd4; res_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    step();
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_sum", 32'(res_sum), 32'd7);
    check("single_cout", 32'(res_cout), 32'd0);
    check("single_id", 32'(res_id), 32'd0);
    // pointer now 1: requester 1 wins over 0
    req_valid = 4'b0011; a_arr[1] = 4'd1; b_arr[1] = 4'd2;
    #1;
    check("ptr_after_single", 32'(req_ready), 32'h2);
    step();

    // overflow wrap
    req_valid = 4'b0100; a_arr[2] = 4'hF; b_arr[2] = 4'h1;
    step();
    check("ovf_sum", 32'(res_sum), 32'h0);
    check("ovf_cout", 32'(res_cout), 32'd1);
    check("ovf_id", 32'(res_id), 32'd2);
    req_valid = '0;
    step();

    // fairness: all valid from reset
    apply_reset();
    res_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) rand_ops(i);
      #1;
      check("rr_grant", 32'(req_ready), 32'(N'(1) << (k % N)));
      step();
      check("rr_id", 32'(res_id), 32'(k % N));
    end

    // backpressure
    apply_reset();
    req_valid = 4'b0001; a_arr[0] = 4'd5; b_arr[0] = 4'd5; res_ready = 1'b1;
    step();
    req_valid = 4'b0010; a_arr[1] = 4'd9; b_arr[1] = 4'd8; res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_sum", 32'(res_sum), 32'hA);
      check("bp_id", 32'(res_id), 32'd0);
      step();
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h2);
    step();
    check("bp_new_sum", 32'(res_sum), 32'h1);
    check("bp_new_cout", 32'(res_cout), 32'd1);
    check("bp_new_id", 32'(res_id), 32'd1);

    // mid-operation reset with a result held
    req_valid = '0; res_ready = 1'b0;
    step();
    check("pre_reset_valid", 32'(res_valid), 32'd1);
    @(negedge clk);
    #2;
    apply_reset();
    req_valid = '1; res_ready = 1'b1;
    #1;
    check("post_reset_grant", 32'(req_ready), 32'h1);
    step();

    // randomized traffic obeying the requester hold rule
    req_valid = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && i == last_grant) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          if (req_valid[i]) rand_ops(i);
        end else if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          if (req_valid[i]) rand_ops(i);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

`ifdef ADDER4_ARB_STATS_EN
    apply_reset();
    req_valid = 4'b0001; res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rand_ops(0);
      step();
    end
    check("stats_5", 32'(txn_count), 32'd5);
    for (int k = 5; k < 70000; k++) step();
    check("stats_sat", 32'(txn_count), 32'hFFFF);
    repeat (5) step();
    check("stats_hold", 32'(txn_count), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
